// File: rtl/alu_pkg.sv
// Shared ALU definitions: legal opcode encodings and the opcode legality check
// used by the receive bridge.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [ALU_OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [ALU_OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [ALU_OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 6'b000010;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/interface_rx_if.sv
// Bundle of UART-side inputs and ALU-side outputs of the receive bridge.
// The bridge takes the slave view; the UART/ALU environment takes the master view.
interface interface_rx_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_full;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic               o_alu_result_ready;
    logic               o_op_error;
    logic               o_timeout;
    logic               o_overrun;

    modport master (
        output i_rx_data, i_rx_done, i_tx_full,
        input  o_data_a, o_data_b, o_op,
        input  o_alu_result_ready, o_op_error, o_timeout, o_overrun
    );

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_full,
        output o_data_a, o_data_b, o_op,
        output o_alu_result_ready, o_op_error, o_timeout, o_overrun
    );
endinterface

// File: rtl/interface_rx_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the last allowed cycle when no clear arrives in it.
module rx_timeout_timer #(
    parameter int unsigned TIMEOUT_TICKS = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_TICKS);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

    logic [CW-1:0] count_q, count_d;

    // A clear in the expiry cycle suppresses expiry, so an arriving byte wins.
    assign expire_o = enable_i && !clear_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i || !enable_i || expire_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/interface_rx.sv
// Receive-side bridge: gathers operand A, operand B and opcode from the UART,
// validates the opcode and issues the frame to the ALU when TX has room.
module interface_rx #(
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned NB_OP         = 6,
    parameter int unsigned TIMEOUT_TICKS = 100000
) (
    input logic            i_clk,
    input logic            i_reset_n,
    interface_rx_if.slave  bus
);
    import alu_pkg::*;

    typedef enum logic [1:0] {IDLE, GET_B, GET_OP, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [NB_OP-1:0]   sh_op_q, sh_op_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               ready_q, ready_d;
    logic               op_err_q, op_err_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               timer_en, timer_clr, expired, op_legal;

    assign timer_en  = (state_q == GET_B) || (state_q == GET_OP);
    assign timer_clr = bus.i_rx_done;
    assign op_legal  = (bus.i_rx_data[NB_DATA-1:NB_OP] == '0) &&
                       is_legal_op(ALU_OP_W'(bus.i_rx_data[NB_OP-1:0]));

    rx_timeout_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
        .clk_i    (i_clk),
        .rst_ni   (i_reset_n),
        .clear_i  (timer_clr),
        .enable_i (timer_en),
        .expire_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        sh_op_d   = sh_op_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        op_d      = op_q;
        ready_d   = 1'b0;
        op_err_d  = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_rx_done) begin
                    sh_a_d  = bus.i_rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.i_rx_done) begin
                    sh_b_d  = bus.i_rx_data;
                    state_d = GET_OP;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            GET_OP: begin
                if (bus.i_rx_done) begin
                    if (op_legal) begin
                        sh_op_d = bus.i_rx_data[NB_OP-1:0];
                        state_d = ISSUE;
                    end else begin
                        op_err_d = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                // A byte landing here is dropped, even on the exit cycle.
                overrun_d = bus.i_rx_done;
                if (!bus.i_tx_full) begin
                    data_a_d = sh_a_q;
                    data_b_d = sh_b_q;
                    op_d     = sh_op_q;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            sh_op_q   <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            op_q      <= '0;
            ready_q   <= 1'b0;
            op_err_q  <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            sh_op_q   <= sh_op_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            op_q      <= op_d;
            ready_q   <= ready_d;
            op_err_q  <= op_err_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.o_data_a           = data_a_q;
    assign bus.o_data_b           = data_b_q;
    assign bus.o_op               = op_q;
    assign bus.o_alu_result_ready = ready_q;
    assign bus.o_op_error         = op_err_q;
    assign bus.o_timeout          = timeout_q;
    assign bus.o_overrun          = overrun_q;
endmodule
